// File: rtl/bus_timer_pkg.sv
// Shared constants for the bus_timer slave: register offsets, CTRL bit
// positions and the bus handshake state encoding.
package bus_timer_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_PRESCALE = 3'd1;
    localparam logic [2:0] REG_COUNT    = 3'd2;
    localparam logic [2:0] REG_COMPARE  = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AR   = 1;
    localparam int CTRL_IE   = 2;
    localparam int CTRL_BITS = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Programmable divider: tick fires once every prescale+1 enabled cycles.
module timer_prescaler #(
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] r_pcnt;

    // ">=" also covers a prescale shrunk below the running count: wrap to 0, no tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pcnt <= '0;
        end else if (!enable || (r_pcnt >= prescale)) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    assign tick = enable && (r_pcnt == prescale);

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped 32-bit timer/compare slave with a 4-phase read/write/response
// handshake: one access per request, response held until the request drops.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter int unsigned PRESCALE_WIDTH = 16,
    parameter logic [31:0] RESET_PRESCALE = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        response,
    output logic        irq
);

    logic [CTRL_BITS-1:0]      r_ctrl;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [31:0]               r_count;
    logic [31:0]               r_compare;
    logic                      r_match;
    bus_state_t                r_state;
    logic                      r_response;
    logic [31:0]               r_read_data;

    logic [2:0]  w_idx;
    logic        w_wr;
    logic        w_wr_count;
    logic        w_tick;
    logic        w_hit;
    logic [31:0] w_rd_mux;
    logic        w_unused;

    assign w_idx      = address[4:2];
    assign w_wr       = (r_state == ST_IDLE) && write;
    assign w_wr_count = w_wr && (w_idx == REG_COUNT);
    // A bus load of COUNT swallows a coincident tick, including its compare.
    assign w_hit      = w_tick && !w_wr_count && (r_count == r_compare);
    assign w_unused   = ^{address[31:5], address[1:0]};

    timer_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .enable  (r_ctrl[CTRL_EN]),
        .prescale(r_prescale),
        .tick    (w_tick)
    );

    always_comb begin
        w_rd_mux = '0;
        case (w_idx)
            REG_CTRL:     w_rd_mux = {{(32-CTRL_BITS){1'b0}}, r_ctrl};
            REG_PRESCALE: w_rd_mux = 32'(r_prescale);
            REG_COUNT:    w_rd_mux = r_count;
            REG_COMPARE:  w_rd_mux = r_compare;
            REG_STATUS:   w_rd_mux = {31'd0, r_match};
            default:      w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ctrl     <= '0;
            r_prescale <= PRESCALE_WIDTH'(RESET_PRESCALE);
            r_count    <= '0;
            r_compare  <= '0;
            r_match    <= 1'b0;
        end else begin
            if (w_wr && (w_idx == REG_CTRL))     r_ctrl     <= write_data[CTRL_BITS-1:0];
            if (w_wr && (w_idx == REG_PRESCALE)) r_prescale <= write_data[PRESCALE_WIDTH-1:0];
            if (w_wr && (w_idx == REG_COMPARE))  r_compare  <= write_data;

            if (w_wr_count) begin
                r_count <= write_data;
            end else if (w_tick) begin
                r_count <= (w_hit && r_ctrl[CTRL_AR]) ? 32'd0 : r_count + 32'd1;
            end

            // A new match beats a simultaneous write-1-to-clear.
            if (w_hit) begin
                r_match <= 1'b1;
            end else if (w_wr && (w_idx == REG_STATUS) && write_data[0]) begin
                r_match <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_response  <= 1'b0;
            r_read_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (read || write) begin
                        r_state     <= ST_ACK;
                        r_response  <= 1'b1;
                        r_read_data <= write ? 32'd0 : w_rd_mux;
                    end
                end
                ST_ACK: begin
                    if (!(read || write)) begin
                        r_state     <= ST_IDLE;
                        r_response  <= 1'b0;
                        r_read_data <= '0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_response  <= 1'b0;
                    r_read_data <= '0;
                end
            endcase
        end
    end

    assign read_data = r_read_data;
    assign response  = r_response;
    assign irq       = r_match & r_ctrl[CTRL_IE];

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: inputs change and outputs are sampled on the
// falling edge, so every bus access lands on the following rising edge.
module tb_bus_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        response;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] A_CTRL = 32'h00;
  localparam logic [31:0] A_PRE  = 32'h04;
  localparam logic [31:0] A_CNT  = 32'h08;
  localparam logic [31:0] A_CMP  = 32'h0C;
  localparam logic [31:0] A_STAT = 32'h10;
  localparam logic [31:0] A_UNM  = 32'h18;

  bus_timer #(
    .PRESCALE_WIDTH(16),
    .RESET_PRESCALE(32'd7)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .read      (read),
    .write     (write),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .response  (response),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; access happens on the next rising edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input string tag);
    address = a;
    write_data = d;
    write = 1'b1;
    @(negedge clk);
    check({tag, "_resp"}, {31'd0, response}, 32'd1);
    write = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    address = a;
    read = 1'b1;
    @(negedge clk);
    check({tag, "_resp"}, {31'd0, response}, 32'd1);
    check(tag, read_data, exp);
    read = 1'b0;
    @(negedge clk);
    check({tag, "_drop"}, {31'd0, response}, 32'd0);
  endtask

  initial begin
    // Reset and register defaults.
    repeat (3) @(negedge clk);
    check("rst_resp", {31'd0, response}, 32'd0);
    check("rst_rdata", read_data, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b1;
    bus_read(A_CTRL, 32'd0, "rst_ctrl");
    bus_read(A_PRE,  32'd7, "rst_pre");
    bus_read(A_CNT,  32'd0, "rst_cnt");
    bus_read(A_CMP,  32'd0, "rst_cmp");
    bus_read(A_STAT, 32'd0, "rst_stat");

    // Free-running compare: ticks at N+4k, match on the 6th tick (COUNT 5->6).
    bus_write(A_PRE, 32'd3, "t2_pre");
    bus_write(A_CMP, 32'd5, "t2_cmp");
    bus_write(A_CTRL, 32'b101, "t2_ctrl");
    repeat (22) @(negedge clk);
    check("t2_irq_before", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("t2_irq_after", {31'd0, irq}, 32'd1);
    bus_read(A_STAT, 32'd1, "t2_stat");
    bus_read(A_CNT,  32'd6, "t2_cnt6");
    bus_read(A_CNT,  32'd7, "t2_cnt7");

    // irq_enable gates irq while match stays set; then prepare auto-reload.
    bus_write(A_CTRL, 32'd0, "t3_stop");
    check("t3_irq_gated", {31'd0, irq}, 32'd0);
    bus_read(A_STAT, 32'd1, "t3_stat_held");
    bus_write(A_CNT, 32'd0, "t3_cnt0");
    bus_write(A_STAT, 32'd1, "t3_w1c");
    bus_read(A_STAT, 32'd0, "t3_stat_clr");
    bus_write(A_CTRL, 32'b111, "t3_ctrl");
    repeat (20) @(negedge clk);
    bus_read(A_CNT, 32'd5, "t3_cnt5");
    check("t3_irq_before", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("t3_irq_after", {31'd0, irq}, 32'd1);
    bus_read(A_CNT, 32'd0, "t3_reload_a");
    bus_read(A_CNT, 32'd0, "t3_reload_b");
    bus_read(A_CNT, 32'd1, "t3_cnt1");
    bus_write(A_STAT, 32'd1, "t3_w1c2");
    check("t3_irq_cleared", {31'd0, irq}, 32'd0);
    // W1C lands on the next matching tick edge: set must win.
    repeat (15) @(negedge clk);
    bus_write(A_STAT, 32'd1, "t3_w1c_race");
    bus_read(A_STAT, 32'd1, "t3_set_wins");
    check("t3_irq_race", {31'd0, irq}, 32'd1);

    // Wrap at 2^32 with PRESCALE=0 (tick every cycle): no match flag.
    bus_write(A_CTRL, 32'd0, "t4_stop");
    bus_write(A_PRE, 32'd0, "t4_pre");
    bus_write(A_CMP, 32'h10, "t4_cmp");
    bus_write(A_STAT, 32'd1, "t4_w1c");
    bus_write(A_CNT, 32'hFFFF_FFFE, "t4_cnt");
    bus_write(A_CTRL, 32'd1, "t4_ctrl");
    bus_read(A_CNT, 32'hFFFF_FFFF, "t4_cnt_max");
    bus_read(A_CNT, 32'h0000_0001, "t4_cnt_wrap");
    bus_read(A_STAT, 32'd0, "t4_no_match");

    // Held read: single snapshot (COUNT=5) kept for the whole ACK phase.
    address = A_CNT;
    read = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_hold_resp", {31'd0, response}, 32'd1);
      check("t5_hold_data", read_data, 32'd5);
    end
    read = 1'b0;
    @(negedge clk);
    check("t5_hold_drop", {31'd0, response}, 32'd0);
    check("t5_hold_rd0", read_data, 32'd0);
    // COUNT write on a tick edge: loaded value wins, one tick later reads +1.
    bus_write(A_CNT, 32'h100, "t5_wcnt");
    bus_read(A_CNT, 32'h101, "t5_cnt_load");
    bus_read(A_STAT, 32'd0, "t5_stat");

    // Reset asserted during ACK.
    address = A_CTRL;
    read = 1'b1;
    @(negedge clk);
    check("t6_resp", {31'd0, response}, 32'd1);
    check("t6_ctrl", read_data, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("t6_rst_resp", {31'd0, response}, 32'd0);
    check("t6_rst_rdata", read_data, 32'd0);
    reset = 1'b1;
    read = 1'b0;
    @(negedge clk);
    bus_read(A_CTRL, 32'd0, "t6_ctrl0");
    bus_read(A_PRE,  32'd7, "t6_pre");
    bus_read(A_CNT,  32'd0, "t6_cnt");
    bus_read(A_CMP,  32'd0, "t6_cmp");
    bus_read(A_STAT, 32'd0, "t6_stat");
    bus_read(A_UNM,  32'd0, "t6_unmapped");

    // Reserved bits, ignored offsets and write-over-read precedence.
    bus_write(A_UNM, 32'hFFFF_FFFF, "t7_wunm");
    bus_read(A_UNM, 32'd0, "t7_unm");
    bus_write(A_CTRL, 32'hFFFF_FFF8, "t7_wctrl");
    bus_read(A_CTRL, 32'd0, "t7_ctrl_rsv");
    address = A_CMP;
    write_data = 32'h33;
    read = 1'b1;
    write = 1'b1;
    @(negedge clk);
    check("t7_both_resp", {31'd0, response}, 32'd1);
    check("t7_both_rdata", read_data, 32'd0);
    read = 1'b0;
    write = 1'b0;
    @(negedge clk);
    bus_read(A_CMP, 32'h33, "t7_cmp");
    check("t7_irq", {31'd0, irq}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
